// File: rtl/commit_queue_pkg.sv
// Shared types and sizing for the in-order commit queue.
// The commit-entry payload struct and the kind encoding live here.
package commit_queue_pkg;

    localparam int DEPTH = 64;
    localparam int IDW   = 8;
    localparam int DESTW = 8;
    localparam int PCW   = 16;

    typedef enum logic {
        KIND_WB = 1'b0,
        KIND_BR = 1'b1
    } kind_e;

    typedef struct packed {
        kind_e              kind;
        logic               fin;
        logic               notify_only;
        logic [DESTW-1:0]   dest_logic;
        logic [1:0]         notify;
        logic [PCW-1:0]     pc;
    } CommitEntry;

endpackage

// File: rtl/commit_entry_ram.sv
// Per-entry payload store: decode fields plus branch outcome.
// Written by enqueue and completion, read asynchronously at the head.
module commit_entry_ram
    import commit_queue_pkg::*;
#(
    parameter int DEPTH = commit_queue_pkg::DEPTH
) (
    input  logic                     clock,
    input  logic                     enq_we,
    input  logic [$clog2(DEPTH)-1:0] enq_idx,
    input  CommitEntry               enq_data,
    input  logic                     cmp_we,
    input  logic [$clog2(DEPTH)-1:0] cmp_idx,
    input  logic                     cmp_miss,
    input  logic [PCW-1:0]           cmp_target,
    input  logic [$clog2(DEPTH)-1:0] head_idx,
    output CommitEntry               head_data,
    output logic                     head_miss,
    output logic [PCW-1:0]           head_target
);

    CommitEntry         payload    [DEPTH];
    logic               miss_mem   [DEPTH];
    logic [PCW-1:0]     target_mem [DEPTH];

    // A fresh entry starts with no miss so a notify_only branch can never
    // inherit a stale outcome; enqueue and completion never hit one slot
    // in the same cycle because completion requires a valid entry.
    always_ff @(posedge clock) begin
        if (enq_we) begin
            payload[enq_idx]    <= enq_data;
            miss_mem[enq_idx]   <= 1'b0;
            target_mem[enq_idx] <= '0;
        end
        if (cmp_we) begin
            miss_mem[cmp_idx]   <= cmp_miss;
            target_mem[cmp_idx] <= cmp_target;
        end
    end

    assign head_data   = payload[head_idx];
    assign head_miss   = miss_mem[head_idx];
    assign head_target = target_mem[head_idx];

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue: allocates ids at decode, collects completions,
// retires in program order and raises flash on a mispredicted branch.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int DEPTH = commit_queue_pkg::DEPTH,
    parameter int IDW   = commit_queue_pkg::IDW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              entry_en,
    input  logic              entry_kind,
    input  logic              entry_fin,
    input  logic              entry_notify_only,
    input  logic [DESTW-1:0]  entry_dest_logic,
    input  logic [1:0]        entry_notify,
    input  logic [PCW-1:0]    entry_pc,
    output logic              entry_reject,
    output logic [IDW-1:0]    commit_id,
    input  logic              complete_en,
    input  logic [IDW-1:0]    complete_id,
    input  logic              complete_miss,
    input  logic [PCW-1:0]    complete_pc,
    output logic              commit_en,
    output logic [DESTW-1:0]  commit_dest_logic,
    output logic [IDW-1:0]    commit_out_id,
    output logic [1:0]        notify,
    output logic              flash,
    output logic [PCW-1:0]    redirect_pc,
    output logic              fin
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IDW-1:0]   head_id;
    logic [IDW-1:0]   tail_id;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] notified;
    logic [IDW-1:0]   entry_id [DEPTH];
    logic             flash_q;
    logic [PCW-1:0]   redirect_q;
    logic             fin_q;

    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic [AW-1:0]    cmp_idx;
    CommitEntry       enq_data;
    CommitEntry       head_data;
    logic             head_miss;
    logic [PCW-1:0]   head_target;

    logic             enq_fire;
    logic             cmp_hit;
    logic             head_valid;
    logic             head_needs_notify;
    logic             notify_fire;
    logic             retire;
    logic             mispredict;

    assign head_idx = head_id[AW-1:0];
    assign tail_idx = tail_id[AW-1:0];
    assign cmp_idx  = complete_id[AW-1:0];

    always_comb begin
        enq_data             = '0;
        enq_data.kind        = kind_e'(entry_kind);
        enq_data.fin         = entry_fin;
        enq_data.notify_only = entry_notify_only;
        enq_data.dest_logic  = entry_dest_logic;
        enq_data.notify      = entry_notify;
        enq_data.pc          = entry_pc;
    end

    // Decode handshake: entry_en is a valid, entry_reject is an inverted ready
    // taken purely from the registered count; an entry transfers in any cycle
    // with entry_en high and entry_reject low, except the flash cycle.
    assign entry_reject = (count == CW'(DEPTH));
    assign enq_fire     = entry_en & ~entry_reject & ~flash_q;
    assign cmp_hit      = complete_en & valid[cmp_idx] &
                          (entry_id[cmp_idx] == complete_id) & ~flash_q;

    assign head_valid        = valid[head_idx];
    assign head_needs_notify = head_valid & (head_data.notify != 2'b00) &
                               ~notified[head_idx];
    assign notify_fire       = head_needs_notify & ~flash_q & ~fin_q;
    assign retire            = head_valid & done[head_idx] & ~head_needs_notify &
                               ~flash_q & ~fin_q;
    assign mispredict        = retire & (head_data.kind == KIND_BR) & head_miss;

    assign commit_id         = tail_id;
    assign commit_en         = retire & (head_data.kind == KIND_WB);
    assign commit_dest_logic = commit_en ? head_data.dest_logic : '0;
    assign commit_out_id     = commit_en ? head_id : '0;
    assign notify            = notify_fire ? head_data.notify : 2'b00;
    assign flash             = flash_q;
    assign redirect_pc       = redirect_q;
    assign fin               = fin_q;

    // The branch pc and notify_only copy are kept with the entry but not
    // consumed at retirement.
    logic unused_head_fields;
    assign unused_head_fields = &{1'b0, head_data.pc, head_data.notify_only};

    always_ff @(posedge clock) begin
        if (reset) begin
            head_id    <= '0;
            tail_id    <= '0;
            count      <= '0;
            flash_q    <= 1'b0;
            redirect_q <= '0;
            fin_q      <= 1'b0;
        end else begin
            flash_q    <= mispredict;
            redirect_q <= mispredict ? head_target : '0;
            if (retire && head_data.fin)
                fin_q <= 1'b1;
            if (retire)
                head_id <= head_id + IDW'(1);
            if (flash_q) begin
                tail_id <= head_id;
                count   <= '0;
            end else begin
                if (enq_fire)
                    tail_id <= tail_id + IDW'(1);
                case ({enq_fire, retire})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid    <= '0;
            done     <= '0;
            notified <= '0;
        end else if (flash_q) begin
            valid <= '0;
        end else begin
            if (cmp_hit)
                done[cmp_idx] <= 1'b1;
            if (notify_fire)
                notified[head_idx] <= 1'b1;
            if (retire)
                valid[head_idx] <= 1'b0;
            if (enq_fire) begin
                valid[tail_idx]    <= 1'b1;
                done[tail_idx]     <= entry_notify_only;
                notified[tail_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire)
            entry_id[tail_idx] <= tail_id;
    end

    commit_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clock       (clock),
        .enq_we      (enq_fire),
        .enq_idx     (tail_idx),
        .enq_data    (enq_data),
        .cmp_we      (cmp_hit),
        .cmp_idx     (cmp_idx),
        .cmp_miss    (complete_miss),
        .cmp_target  (complete_pc),
        .head_idx    (head_idx),
        .head_data   (head_data),
        .head_miss   (head_miss),
        .head_target (head_target)
    );

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue: a per-cycle vector table for the basic
// enqueue/complete/notify flow, then sequences for full, flash, wrap and fin.
module tb_commit_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        entry_en;
    logic        entry_kind;
    logic        entry_fin;
    logic        entry_notify_only;
    logic [7:0]  entry_dest_logic;
    logic [1:0]  entry_notify;
    logic [15:0] entry_pc;
    logic        entry_reject;
    logic [7:0]  commit_id;
    logic        complete_en;
    logic [7:0]  complete_id;
    logic        complete_miss;
    logic [15:0] complete_pc;
    logic        commit_en;
    logic [7:0]  commit_dest_logic;
    logic [7:0]  commit_out_id;
    logic [1:0]  notify;
    logic        flash;
    logic [15:0] redirect_pc;
    logic        fin;

    always #5 clock = ~clock;

    commit_queue #(.DEPTH(64), .IDW(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .entry_en          (entry_en),
        .entry_kind        (entry_kind),
        .entry_fin         (entry_fin),
        .entry_notify_only (entry_notify_only),
        .entry_dest_logic  (entry_dest_logic),
        .entry_notify      (entry_notify),
        .entry_pc          (entry_pc),
        .entry_reject      (entry_reject),
        .commit_id         (commit_id),
        .complete_en       (complete_en),
        .complete_id       (complete_id),
        .complete_miss     (complete_miss),
        .complete_pc       (complete_pc),
        .commit_en         (commit_en),
        .commit_dest_logic (commit_dest_logic),
        .commit_out_id     (commit_out_id),
        .notify            (notify),
        .flash             (flash),
        .redirect_pc       (redirect_pc),
        .fin               (fin)
    );

    typedef struct {
        logic       en;
        logic       nonly;
        logic [7:0] dest;
        logic [1:0] ntf;
        logic       cen;
        logic [7:0] cid;
        logic       x_rej;
        logic [7:0] x_cid;
        logic       x_cen;
        logic [7:0] x_dest;
        logic [7:0] x_oid;
        logic [1:0] x_ntf;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          flash_cnt = 0;
    logic [15:0] last_redirect = '0;
    vec_t        vecs[17];

    function automatic vec_t mk(input logic en, input logic nonly, input logic [7:0] dest,
                                input logic [1:0] ntf, input logic cen, input logic [7:0] cid,
                                input logic x_rej, input logic [7:0] x_cid, input logic x_cen,
                                input logic [7:0] x_dest, input logic [7:0] x_oid,
                                input logic [1:0] x_ntf);
        vec_t v;
        v.en = en; v.nonly = nonly; v.dest = dest; v.ntf = ntf; v.cen = cen; v.cid = cid;
        v.x_rej = x_rej; v.x_cid = x_cid; v.x_cen = x_cen; v.x_dest = x_dest;
        v.x_oid = x_oid; v.x_ntf = x_ntf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic idle_in();
        entry_en = 0; entry_kind = 0; entry_fin = 0; entry_notify_only = 0;
        entry_dest_logic = 0; entry_notify = 0; entry_pc = 0;
        complete_en = 0; complete_id = 0; complete_miss = 0; complete_pc = 0;
    endtask

    task automatic enq(input logic kind, input logic f, input logic nonly,
                       input logic [7:0] dest, input logic [1:0] ntf, input logic [15:0] pc);
        entry_en = 1; entry_kind = kind; entry_fin = f; entry_notify_only = nonly;
        entry_dest_logic = dest; entry_notify = ntf; entry_pc = pc;
    endtask

    task automatic cmp(input logic [7:0] id, input logic miss, input logic [15:0] pc);
        complete_en = 1; complete_id = id; complete_miss = miss; complete_pc = pc;
    endtask

    // Scoreboard: every commit_en must match the oldest expected {id, dest}.
    task automatic monitor();
        logic [15:0] e;
        if (commit_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_commit actual=id 0x%0h dest 0x%0h required=no retire",
                         commit_out_id, commit_dest_logic);
            end else begin
                e = exp_q.pop_front();
                chk("commit_order", {16'h0, commit_out_id, commit_dest_logic}, {16'h0, e});
            end
        end
        if (flash) begin
            flash_cnt++;
            last_redirect = redirect_pc;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        if (mon_en) monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_in();
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reject"}, entry_reject, 0);
        chk({tag, "_commit_id"}, commit_id, 0);
        chk({tag, "_commit_en"}, commit_en, 0);
        chk({tag, "_dest"}, commit_dest_logic, 0);
        chk({tag, "_out_id"}, commit_out_id, 0);
        chk({tag, "_notify"}, notify, 0);
        chk({tag, "_flash"}, flash, 0);
        chk({tag, "_redirect"}, redirect_pc, 0);
        chk({tag, "_fin"}, fin, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cids[5];
        cids = '{0, 1, 2, 3, 6};

        //            en nonly dest   ntf    cen cid    rej cid    cen dest   oid    ntf
        vecs[0]  = mk(1, 0, 8'h05, 2'b00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 2'b00);
        vecs[1]  = mk(1, 0, 8'h06, 2'b00, 0, 8'h00, 0, 8'h01, 0, 8'h00, 8'h00, 2'b00);
        vecs[2]  = mk(1, 0, 8'h07, 2'b00, 0, 8'h00, 0, 8'h02, 0, 8'h00, 8'h00, 2'b00);
        vecs[3]  = mk(0, 0, 8'h00, 2'b00, 1, 8'h02, 0, 8'h03, 0, 8'h00, 8'h00, 2'b00);
        vecs[4]  = mk(0, 0, 8'h00, 2'b00, 1, 8'h00, 0, 8'h03, 0, 8'h00, 8'h00, 2'b00);
        vecs[5]  = mk(0, 0, 8'h00, 2'b00, 1, 8'h01, 0, 8'h03, 1, 8'h05, 8'h00, 2'b00);
        vecs[6]  = mk(0, 0, 8'h00, 2'b00, 1, 8'h01, 0, 8'h03, 1, 8'h06, 8'h01, 2'b00);
        vecs[7]  = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h03, 1, 8'h07, 8'h02, 2'b00);
        vecs[8]  = mk(1, 0, 8'h09, 2'b01, 0, 8'h00, 0, 8'h03, 0, 8'h00, 8'h00, 2'b00);
        vecs[9]  = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h04, 0, 8'h00, 8'h00, 2'b01);
        vecs[10] = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h04, 0, 8'h00, 8'h00, 2'b00);
        vecs[11] = mk(0, 0, 8'h00, 2'b00, 1, 8'h03, 0, 8'h04, 0, 8'h00, 8'h00, 2'b00);
        vecs[12] = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h04, 1, 8'h09, 8'h03, 2'b00);
        vecs[13] = mk(1, 1, 8'h0A, 2'b10, 0, 8'h00, 0, 8'h04, 0, 8'h00, 8'h00, 2'b00);
        vecs[14] = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h05, 0, 8'h00, 8'h00, 2'b10);
        vecs[15] = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h05, 1, 8'h0A, 8'h04, 2'b00);
        vecs[16] = mk(0, 0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h05, 0, 8'h00, 8'h00, 2'b00);

        reset = 1;
        idle_in();
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 0;

        for (int i = 0; i < 17; i++) begin
            idle_in();
            if (vecs[i].en) enq(0, 0, vecs[i].nonly, vecs[i].dest, vecs[i].ntf, 16'h0);
            if (vecs[i].cen) cmp(vecs[i].cid, 0, 16'h0);
            @(negedge clock);
            chk("tbl_reject", entry_reject, vecs[i].x_rej);
            chk("tbl_commit_id", commit_id, vecs[i].x_cid);
            chk("tbl_commit_en", commit_en, vecs[i].x_cen);
            chk("tbl_notify", notify, vecs[i].x_ntf);
            chk("tbl_flash", flash, 0);
            if (vecs[i].x_cen) begin
                chk("tbl_dest", commit_dest_logic, vecs[i].x_dest);
                chk("tbl_out_id", commit_out_id, vecs[i].x_oid);
            end
            @(posedge clock);
            #1;
        end

        // Fill to capacity, then retire one while decode keeps offering.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            enq(0, 0, 0, 8'(i), 2'b00, 16'h0);
            chk("fill_commit_id", commit_id, i);
            cycle();
        end
        chk("full_reject", entry_reject, 1);
        cmp(8'd0, 0, 16'h0);
        cycle();
        complete_en = 0;
        chk("reject_in_retire_cycle", entry_reject, 1);
        chk("full_retire_en", commit_en, 1);
        chk("full_retire_id", commit_out_id, 0);
        cycle();
        chk("reject_after_retire", entry_reject, 0);
        chk("id_after_full", commit_id, 64);
        cycle();
        chk("refull_reject", entry_reject, 1);
        chk("refull_commit_id", commit_id, 65);
        idle_in();
        cycle();

        // Mispredicted branch at id 4 with younger 5..9 pending (6 completed).
        do_reset();
        mon_en = 1;
        flash_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle_in();
            enq(i == 4, 0, 0, 8'h20 + 8'(i), 2'b00, 16'h0400);
            chk("mp_commit_id", commit_id, i);
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            idle_in();
            cmp(8'(cids[k]), 0, 16'h0);
            if (cids[k] < 4) exp_q.push_back({8'(cids[k]), 8'h20 + 8'(cids[k])});
            cycle();
        end
        idle_in();
        cmp(8'd4, 1, 16'h0123);
        cycle();
        idle_in();
        repeat (6) cycle();
        chk("flash_pulses", flash_cnt, 1);
        chk("redirect_pc", last_redirect, 16'h0123);
        chk("mp_retired_all_older", exp_q.size(), 0);
        chk("mp_tail_rewound", commit_id, 5);
        chk("mp_reject", entry_reject, 0);
        enq(0, 0, 0, 8'h55, 2'b00, 16'h0);
        chk("mp_next_id", commit_id, 5);
        cycle();
        idle_in();
        chk("mp_next_accepted", commit_id, 6);
        cmp(8'd6, 0, 16'h0);
        cycle();
        idle_in();
        repeat (3) cycle();
        cmp(8'd5, 0, 16'h0);
        exp_q.push_back({8'd5, 8'h55});
        cycle();
        idle_in();
        repeat (3) cycle();
        chk("mp_new_entry_retired", exp_q.size(), 0);

        // 300 entries through the queue: ids wrap 255 -> 0.
        do_reset();
        for (int i = 0; i < 302; i++) begin
            idle_in();
            if (i < 300) begin
                enq(0, 0, 0, 8'(i) ^ 8'h5A, 2'b00, 16'h0);
                chk("wrap_commit_id", commit_id, i % 256);
            end
            if (i >= 2) begin
                cmp(8'((i - 2) % 256), 0, 16'h0);
                exp_q.push_back({8'((i - 2) % 256), 8'(i - 2) ^ 8'h5A});
            end
            cycle();
        end
        idle_in();
        repeat (4) cycle();
        chk("wrap_all_retired", exp_q.size(), 0);

        // Fin halts retirement; enqueue keeps going; reset clears everything.
        do_reset();
        enq(0, 1, 0, 8'h33, 2'b00, 16'h0);
        cycle();
        idle_in();
        enq(0, 0, 0, 8'h44, 2'b00, 16'h0);
        cmp(8'd0, 0, 16'h0);
        exp_q.push_back({8'h00, 8'h33});
        cycle();
        idle_in();
        cmp(8'd1, 0, 16'h0);
        cycle();
        idle_in();
        chk("fin_set", fin, 1);
        repeat (5) cycle();
        chk("fin_sticky", fin, 1);
        chk("fin_retired_once", exp_q.size(), 0);
        enq(0, 0, 0, 8'h66, 2'b00, 16'h0);
        chk("fin_enq_id2", commit_id, 2);
        cycle();
        chk("fin_enq_id3", commit_id, 3);
        cycle();
        idle_in();
        cycle();
        chk("fin_before_reset", fin, 1);
        mon_en = 0;
        reset = 1;
        @(posedge clock);
        #1;
        chk_all_zero("midreset");
        reset = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
